// File: rtl/stretcher_pkg.sv
// rtl/stretcher_pkg.sv - shared channel state type and default bank sizing
package stretcher_pkg;

    localparam int DEFAULT_COUNT = 8;
    localparam int DEFAULT_BITS  = 20;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/stretch_channel.sv
// rtl/stretch_channel.sv - one stretcher channel: synchronizer, optional filter, hold FSM, sticky flag
// Optional majority deglitch filter: PULSE_STRETCHER_BANK_DEGLITCH_EN
module stretch_channel
    import stretcher_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_i,
    input  logic [BITS-1:0] hold_i,
    input  logic            retrigger_i,
    input  logic            clear_sticky_i,
    output logic            out_o,
    output logic            sticky_o
);

    logic            s1_q;
    logic            s2_q;
    logic            f;
    logic            f_prev_q;
    state_t          state_q;
    logic [BITS-1:0] cnt_q;
    logic            sticky_q;
    logic            sticky_d;
    logic            enter;
    logic            rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= in_i;
            s2_q <= s1_q;
        end
    end

`ifdef PULSE_STRETCHER_BANK_DEGLITCH_EN
    logic d1_q;
    logic d2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            d1_q <= s2_q;
            d2_q <= d1_q;
        end
    end

    // Two of the last three synchronized samples must agree, so a lone sample never passes.
    assign f = (s2_q & d1_q) | (s2_q & d2_q) | (d1_q & d2_q);
`else
    assign f = s2_q;
`endif

    assign rise     = f & ~f_prev_q;
    assign enter    = (state_q == IDLE) && f;
    assign sticky_d = enter | (sticky_q & ~clear_sticky_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f_prev_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            f_prev_q <= f;
            sticky_q <= sticky_d;
            case (state_q)
                IDLE: begin
                    if (f) begin
                        state_q <= HOLD;
                        cnt_q   <= hold_i;
                    end
                end
                HOLD: begin
                    // Reload wins over both decrement and exit; counter parks at zero while f stays high.
                    if (retrigger_i && rise) begin
                        cnt_q <= hold_i;
                    end else if (cnt_q == '0) begin
                        if (!f) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_o    = (state_q == HOLD);
    assign sticky_o = sticky_q;

endmodule

// File: rtl/pulse_stretcher_bank.sv
// rtl/pulse_stretcher_bank.sv - bank of independent pulse stretchers with shared hold length
// Optional majority deglitch filter: PULSE_STRETCHER_BANK_DEGLITCH_EN
module pulse_stretcher_bank
    import stretcher_pkg::*;
#(
    parameter int COUNT = DEFAULT_COUNT,
    parameter int BITS  = DEFAULT_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COUNT-1:0] in,
    input  logic [BITS-1:0]  hold,
    input  logic             retrigger,
    input  logic [COUNT-1:0] clear_sticky,
    output logic [COUNT-1:0] out,
    output logic [COUNT-1:0] sticky,
    output logic             any_out
);

    for (genvar i = 0; i < COUNT; i++) begin : g_ch
        stretch_channel #(
            .BITS(BITS)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .in_i          (in[i]),
            .hold_i        (hold),
            .retrigger_i   (retrigger),
            .clear_sticky_i(clear_sticky[i]),
            .out_o         (out[i]),
            .sticky_o      (sticky[i])
        );
    end

    assign any_out = |out;

endmodule

// File: tb/tb_pulse_stretcher_bank.sv
// tb/tb_pulse_stretcher_bank.sv - scoreboard bench for pulse_stretcher_bank (COUNT=4, BITS=4)
module tb_pulse_stretcher_bank;

    localparam int NCH = 4;
`ifdef PULSE_STRETCHER_BANK_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset_r;
    logic [3:0] in_r;
    logic [3:0] hold_r;
    logic       retrig_r;
    logic [3:0] clr_r;
    wire  [3:0] out_w;
    wire  [3:0] sticky_w;
    wire        any_w;

    always #5 clk = ~clk;

    pulse_stretcher_bank #(.COUNT(4), .BITS(4)) dut (
        .clk         (clk),
        .reset       (reset_r),
        .in          (in_r),
        .hold        (hold_r),
        .retrigger   (retrig_r),
        .clear_sticky(clr_r),
        .out         (out_w),
        .sticky      (sticky_w),
        .any_out     (any_w)
    );

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] s;
        logic       a;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: raw input history per channel and a "stay high until edge" deadline.
    logic [3:0] hist   [NCH];
    logic       fprev_m[NCH];
    logic       act_m  [NCH];
    int         end_m  [NCH];
    logic       stk_m  [NCH];
    int         t_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, t_m);
        end
    endtask

    function automatic logic f_of(input int ch);
`ifdef PULSE_STRETCHER_BANK_DEGLITCH_EN
        return (hist[ch][1] & hist[ch][2]) | (hist[ch][1] & hist[ch][3]) | (hist[ch][2] & hist[ch][3]);
`else
        return hist[ch][1];
`endif
    endfunction

    task automatic model_edge();
        exp_t e;
        logic f;
        logic enter;
        t_m++;
        e = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset_r) begin
                hist[ch]    = '0;
                fprev_m[ch] = 1'b0;
                act_m[ch]   = 1'b0;
                end_m[ch]   = 0;
                stk_m[ch]   = 1'b0;
            end else begin
                f     = f_of(ch);
                enter = 1'b0;
                if (!act_m[ch]) begin
                    if (f) begin
                        act_m[ch] = 1'b1;
                        end_m[ch] = t_m + int'(hold_r);
                        enter     = 1'b1;
                    end
                end else if (retrig_r && f && !fprev_m[ch]) begin
                    end_m[ch] = t_m + int'(hold_r);
                end else if (t_m > end_m[ch] && !f) begin
                    act_m[ch] = 1'b0;
                end
                stk_m[ch]   = enter ? 1'b1 : (clr_r[ch] ? 1'b0 : stk_m[ch]);
                fprev_m[ch] = f;
                hist[ch]    = {hist[ch][2:0], in_r[ch]};
            end
            e.o[ch] = act_m[ch];
            e.s[ch] = stk_m[ch];
        end
        e.a = |e.o;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out", 32'(out_w), 32'(e.o));
            check("sticky", 32'(sticky_w), 32'(e.s));
            check("any_out", 32'(any_w), 32'(e.a));
        end
    end

    task automatic step(input logic [3:0] i, input logic [3:0] h, input logic r,
                        input logic [3:0] c, input logic rs);
        in_r     = i;
        hold_r   = h;
        retrig_r = r;
        clr_r    = c;
        reset_r  = rs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0, 4'd0, 1'b1, 4'b0, 1'b0);
    endtask

    task automatic pulse_test(input string name, input int ch, input logic [3:0] h, input logic rt,
                              input int w1, input int gap, input int w2,
                              input int exp_hi, input int exp_rise);
        int         hi;
        int         rise;
        logic [3:0] iv;
        hi   = 0;
        rise = -1;
        for (int k = 1; k <= 24; k++) begin
            iv = '0;
            if (k <= w1 || (k > w1 + gap && k <= w1 + gap + w2)) iv[ch] = 1'b1;
            step(iv, h, rt, 4'b0, 1'b0);
            if (out_w[ch] === 1'b1) begin
                hi++;
                if (rise < 0) rise = k;
            end
        end
        check({name, "_high_cycles"}, hi, exp_hi);
        check({name, "_rise_delay"}, rise, exp_rise);
    endtask

    initial begin
        int         lat;
        logic [3:0] iv;
        logic [3:0] cv;
        logic       rt;
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch]    = '0;
            fprev_m[ch] = 1'b0;
            act_m[ch]   = 1'b0;
            end_m[ch]   = 0;
            stk_m[ch]   = 1'b0;
        end

        step(4'b0, 4'd0, 1'b0, 4'b0, 1'b1);
        step(4'b0, 4'd0, 1'b0, 4'b0, 1'b1);
        check("reset_out", 32'(out_w), 32'd0);
        check("reset_sticky", 32'(sticky_w), 32'd0);
        check("reset_any", 32'(any_w), 32'd0);

`ifdef PULSE_STRETCHER_BANK_DEGLITCH_EN
        pulse_test("glitch1", 0, 4'd3, 1'b1, 1, 0, 0, 0, -1);
        pulse_test("pulse2", 0, 4'd3, 1'b1, 2, 0, 0, 4, 4);
        pulse_test("long10", 1, 4'd2, 1'b1, 10, 0, 0, 10, 4);
        pulse_test("hold0", 3, 4'd0, 1'b1, 2, 0, 0, 2, 4);
`else
        pulse_test("single", 0, 4'd5, 1'b1, 1, 0, 0, 6, 3);
        pulse_test("long10", 1, 4'd2, 1'b1, 10, 0, 0, 10, 3);
        pulse_test("retrig", 2, 4'd4, 1'b1, 1, 2, 1, 8, 3);
        pulse_test("noretrig", 2, 4'd4, 1'b0, 1, 2, 1, 5, 3);
        pulse_test("hold0", 3, 4'd0, 1'b1, 1, 0, 0, 1, 3);
`endif

        step(4'b0, 4'd0, 1'b1, 4'b0001, 1'b0);
        check("sticky_clear_alone", 32'(sticky_w[0]), 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            iv = (k <= 2) ? 4'b0001 : 4'b0000;
            cv = (k == LAT) ? 4'b0001 : 4'b0000;
            step(iv, 4'd3, 1'b1, cv, 1'b0);
        end
        check("sticky_set_wins", 32'(sticky_w[0]), 32'd1);
        check("sticky_set_out", 32'(out_w[0]), 32'd1);
        idle(12);
        step(4'b0, 4'd0, 1'b1, 4'b0001, 1'b0);
        check("sticky_clear_again", 32'(sticky_w[0]), 32'd0);

        for (int k = 1; k <= 5; k++) step(4'b1000, 4'd5, 1'b1, 4'b0, 1'b0);
        step(4'b1000, 4'd5, 1'b1, 4'b0, 1'b1);
        check("midhold_reset_out", 32'(out_w[3]), 32'd0);
        check("midhold_reset_sticky", 32'(sticky_w[3]), 32'd0);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step(4'b1000, 4'd5, 1'b1, 4'b0, 1'b0);
            if (out_w[3] === 1'b1 && lat == 0) lat = k;
        end
        check("release_latency", lat, LAT);
        idle(20);

        rt = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            iv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            cv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) rt = ~rt;
            step(iv, 4'($urandom_range(0, 15)), rt, cv, ($urandom_range(0, 199) == 0));
        end
        for (int k = 0; k < 600; k++) begin
            iv = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            step(iv, 4'($urandom_range(0, 3)), 1'b1, 4'b0, 1'b0);
        end
        idle(24);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher_bank.md
PULSE_STRETCHER_BANK -- requirements
Module: pulse_stretcher_bank

Interface
REQ-001 SHALL have parameter COUNT, default 8: number of independent channels.
REQ-002 SHALL have parameter BITS, default 20: hold counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in, input, COUNT: asynchronous raw event inputs.
REQ-006 SHALL have port hold, input, BITS: runtime hold length shared by all channels.
REQ-007 SHALL have port retrigger, input, 1: 1 means a new rising edge during hold reloads the counter.
REQ-008 SHALL have port clear_sticky, input, COUNT: per-channel sticky clear.
REQ-009 SHALL have port out, output, COUNT: registered stretched outputs.
REQ-010 SHALL have port sticky, output, COUNT: registered per-channel "event seen" flags.
REQ-011 SHALL have port any_out, output, 1: OR of all out bits, with no added latency.

Function
REQ-012 Each in[i] SHALL pass a two-flop synchronizer; the second-stage value is the channel's filtered signal f, unless deglitch is compiled in.
REQ-013 Each channel SHALL be a two-state FSM, IDLE and HOLD; out[i] SHALL be 1 exactly while the registered state is HOLD.
REQ-014 In IDLE with f=1, the channel SHALL enter HOLD at the next edge and load counter with hold.
REQ-015 In HOLD with counter==0 and f==0, the channel SHALL return to IDLE at the next edge.
REQ-016 Otherwise in HOLD, counter SHALL decrement when nonzero and SHALL saturate at 0.
REQ-017 With retrigger=1, a rising edge of f (f & ~f_prev) in HOLD SHALL reload counter with hold; this takes priority over decrement.
REQ-018 With retrigger=0, rising edges of f in HOLD SHALL be ignored; out still stays high while f=1.
REQ-019 Resulting out high time SHALL be max(f-high cycles, hold+1); hold=0 SHALL give a 1-cycle minimum.
REQ-020 hold SHALL be sampled only on entry or reload; changes mid-hold SHALL NOT affect the running count.
REQ-021 Latency from in rising to out rising SHALL be 3 clk cycles with deglitch off, 4 with deglitch on.
REQ-022 sticky[i] SHALL set on the IDLE->HOLD transition and clear on clear_sticky[i]; a simultaneous set and clear SHALL leave sticky=1.
REQ-023 Channels SHALL be fully independent; simultaneous events on all channels SHALL be handled without interaction.

Reset
REQ-024 reset SHALL force synchronizer, filter and f_prev registers, state=IDLE, counter=0, out=0, sticky=0 and any_out=0 at the next edge.
REQ-025 reset SHALL take priority over all inputs, including mid-HOLD operation.
REQ-026 An input held high through reset release SHALL be treated as a new edge with normal latency.

Configuration
REQ-027 Macro PULSE_STRETCHER_BANK_DEGLITCH_EN defined SHALL add a 3-sample majority filter: f = maj(s2, s2 delayed 1, s2 delayed 2).
REQ-028 With the filter, single-cycle synchronized pulses SHALL be suppressed and latency SHALL increase by 1 cycle.
REQ-029 With the macro undefined, f SHALL equal s2 and no filter registers SHALL exist.

Structure
REQ-030 Shared package stretcher_pkg SHALL hold the state typedef (IDLE, HOLD) and the default COUNT/BITS constants.
REQ-031 Per-channel logic SHALL be sub-module stretch_channel, instantiated COUNT times via generate; any_out SHALL be the OR in the top level.

Verification (COUNT=4, BITS=4, macro off unless stated)
REQ-032 hold=5, in[0] high 1 cycle -> out[0] and any_out high 6 cycles starting 3 cycles later; sticky[0]=1.
REQ-033 hold=2, in[1] high 10 cycles -> out[1] high exactly 10 cycles.
REQ-034 hold=4, two 1-cycle pulses on in[2] with f rising edges 3 cycles apart -> out high 8 cycles with retrigger=1, 5 cycles with retrigger=0.
REQ-035 clear_sticky[0] asserted in the same cycle as a new set -> sticky[0] stays 1; clear alone -> sticky[0]=0 next cycle.
REQ-036 reset asserted mid-HOLD (counter=3) -> out=0 and sticky=0 after the next edge; in still high afterwards -> out rises 3 cycles after reset release.
REQ-037 Macro on, hold=3: 1-cycle in pulse -> out never rises; 2-cycle pulse -> out high 4 cycles starting 4 cycles later.
